// File: rtl/expr_vec_sched.sv
// expr_vec_sched: drives pseudo-random operand vectors to an external expression
// datapath and folds its results into a 32-bit MISR signature.
//
// Ports:
//   clk        in   1   rising-edge clock
//   rst        in   1   synchronous active-high reset
//   start      in   1   run request, accepted only while idle
//   seed       in  32   operand LFSR seed (zero maps to 1), sampled on accepted start
//   num_vec    in  16   number of vectors in the run, sampled on accepted start
//   stall      in   1   freezes all run-time state while high
//   op_bus     out 60   operand vector for the datapath, zero outside RUN
//   dut_y      in  90   datapath result for op_bus
//   busy       out  1   high while running
//   done       out  1   one-cycle completion pulse
//   signature  out 32   MISR value, held until the next accepted start
//   vec_cnt    out 16   vectors sampled in the current or last run
module expr_vec_sched #(
   parameter int unsigned SETTLE    = 0,
   parameter logic [31:0] LFSR_POLY = 32'hB4BC_D35C,
   parameter logic [31:0] MISR_POLY = 32'h04C1_1DB7
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] seed,
   input  logic [15:0] num_vec,
   input  logic        stall,
   output logic [59:0] op_bus,
   input  logic [89:0] dut_y,
   output logic        busy,
   output logic        done,
   output logic [31:0] signature,
   output logic [15:0] vec_cnt
);

   localparam logic [1:0] StIdle   = 2'd0;
   localparam logic [1:0] StRun    = 2'd1;
   localparam logic [1:0] StFinish = 2'd2;

   localparam logic [3:0] SettleMax = 4'(SETTLE);

   logic [1:0]  state_q, state_d;
   logic [31:0] lfsr_q, lfsr_d;
   logic [31:0] sig_q, sig_d;
   logic [15:0] vec_cnt_q, vec_cnt_d;
   logic [15:0] num_q, num_d;
   logic [3:0]  settle_q, settle_d;

   function automatic logic [31:0] lfsr_step(input logic [31:0] l);
      return (l >> 1) ^ (l[0] ? LFSR_POLY : 32'h0);
   endfunction

   // Result is compressed to 32 bits by XOR-folding the three result slices.
   function automatic logic [31:0] misr_next(input logic [31:0] s, input logic [89:0] y);
      return {s[30:0], 1'b0} ^ (s[31] ? MISR_POLY : 32'h0)
             ^ y[31:0] ^ y[63:32] ^ {6'b0, y[89:64]};
   endfunction

   always_comb begin
      state_d   = state_q;
      lfsr_d    = lfsr_q;
      sig_d     = sig_q;
      vec_cnt_d = vec_cnt_q;
      num_d     = num_q;
      settle_d  = settle_q;
      case (state_q)
         StIdle: begin
            if (start) begin
               lfsr_d    = (seed == 32'h0) ? 32'h1 : seed;
               sig_d     = 32'hFFFF_FFFF;
               vec_cnt_d = 16'h0;
               settle_d  = 4'h0;
               num_d     = num_vec;
               state_d   = (num_vec == 16'h0) ? StFinish : StRun;
            end
         end
         StRun: begin
            if (!stall) begin
               if (settle_q != SettleMax) begin
                  settle_d = settle_q + 4'h1;
               end else begin
                  sig_d     = misr_next(sig_q, dut_y);
                  lfsr_d    = lfsr_step(lfsr_q);
                  vec_cnt_d = vec_cnt_q + 16'h1;
                  settle_d  = 4'h0;
                  // Leave RUN on the same edge the last vector is sampled.
                  if (vec_cnt_d == num_q) begin
                     state_d = StFinish;
                  end
               end
            end
         end
         StFinish: state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         lfsr_q    <= 32'h0;
         sig_q     <= 32'h0;
         vec_cnt_q <= 16'h0;
         num_q     <= 16'h0;
         settle_q  <= 4'h0;
      end else begin
         state_q   <= state_d;
         lfsr_q    <= lfsr_d;
         sig_q     <= sig_d;
         vec_cnt_q <= vec_cnt_d;
         num_q     <= num_d;
         settle_q  <= settle_d;
      end
   end

   assign busy      = (state_q == StRun);
   assign done      = (state_q == StFinish);
   assign signature = sig_q;
   assign vec_cnt   = vec_cnt_q;
   assign op_bus    = busy ? {lfsr_q[27:0], lfsr_q} : 60'h0;

endmodule

// File: tb/tb_expr_vec_sched.sv
// Bench for expr_vec_sched: two instances (SETTLE=0 and SETTLE=2) share all inputs.
// A run-level model predicts each instance's outputs from the vector index of the
// run (non-stalled busy cycles / (SETTLE+1)) and a precomputed LFSR sequence.
module tb_expr_vec_sched;

   logic        clk = 1'b0;
   logic        rst, start, stall;
   logic [31:0] seed;
   logic [15:0] num_vec;
   logic [89:0] dut_y;

   logic [59:0] op0, op2;
   logic        busy0, busy2, done0, done2;
   logic [31:0] sig0, sig2;
   logic [15:0] cnt0, cnt2;

   always #5 clk = ~clk;

   expr_vec_sched #(.SETTLE(0)) u_dut0 (
      .clk(clk), .rst(rst), .start(start), .seed(seed), .num_vec(num_vec), .stall(stall),
      .op_bus(op0), .dut_y(dut_y), .busy(busy0), .done(done0), .signature(sig0),
      .vec_cnt(cnt0)
   );

   expr_vec_sched #(.SETTLE(2)) u_dut2 (
      .clk(clk), .rst(rst), .start(start), .seed(seed), .num_vec(num_vec), .stall(stall),
      .op_bus(op2), .dut_y(dut_y), .busy(busy2), .done(done2), .signature(sig2),
      .vec_cnt(cnt2)
   );

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string name, input logic [89:0] got, input logic [89:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, got, want);
      end
   endtask

   function automatic logic [31:0] step(input logic [31:0] l);
      return (l >> 1) ^ (l[0] ? 32'hB4BC_D35C : 32'h0);
   endfunction

   function automatic logic [31:0] misr(input logic [31:0] s, input logic [89:0] y);
      return {s[30:0], 1'b0} ^ (s[31] ? 32'h04C1_1DB7 : 32'h0)
             ^ y[31:0] ^ y[63:32] ^ {6'b0, y[89:64]};
   endfunction

   function automatic int per_vec(input int i);
      return (i == 0) ? 1 : 3;
   endfunction

   // ---------------- model ----------------
   bit          m_run [2];
   bit          m_fin [2];
   int          m_act [2];
   int          m_n   [2];
   logic [31:0] m_sig [2];
   logic [31:0] lseq  [2][2048];

   initial begin
      for (int i = 0; i < 2; i++) begin
         m_run[i] = 1'b0; m_fin[i] = 1'b0; m_act[i] = 0; m_n[i] = 0; m_sig[i] = 32'h0;
      end
      forever begin
         @(posedge clk);
         for (int i = 0; i < 2; i++) begin
            if (rst) begin
               m_run[i] = 1'b0; m_fin[i] = 1'b0; m_act[i] = 0; m_sig[i] = 32'h0;
            end else if (m_fin[i]) begin
               m_fin[i] = 1'b0;
            end else if (!m_run[i]) begin
               if (start) begin
                  m_n[i]     = int'(num_vec);
                  m_act[i]   = 0;
                  m_sig[i]   = 32'hFFFF_FFFF;
                  lseq[i][0] = (seed == 32'h0) ? 32'h1 : seed;
                  for (int k = 1; k < m_n[i] && k < 2048; k++) lseq[i][k] = step(lseq[i][k-1]);
                  if (m_n[i] == 0) m_fin[i] = 1'b1;
                  else             m_run[i] = 1'b1;
               end
            end else if (!stall) begin
               // Last slot of each vector's window is where the result is taken.
               if (m_act[i] % per_vec(i) == per_vec(i) - 1) m_sig[i] = misr(m_sig[i], dut_y);
               m_act[i]++;
               if (m_act[i] == m_n[i] * per_vec(i)) begin
                  m_run[i] = 1'b0;
                  m_fin[i] = 1'b1;
               end
            end
         end
      end
   end

   task automatic check_inst(input string tag, input int i, input logic b, input logic d,
                             input logic [31:0] sg, input logic [15:0] vc,
                             input logic [59:0] op);
      int          idx;
      logic [31:0] l;
      logic [59:0] eop;
      idx = (m_act[i] / per_vec(i)) % 2048;
      l   = lseq[i][idx];
      eop = m_run[i] ? {l[27:0], l} : 60'h0;
      chk({tag, ".busy"}, 90'(b), 90'(m_run[i]));
      chk({tag, ".done"}, 90'(d), 90'(m_fin[i]));
      chk({tag, ".signature"}, 90'(sg), 90'(m_sig[i]));
      chk({tag, ".vec_cnt"}, 90'(vc), 90'(16'(m_act[i] / per_vec(i))));
      chk({tag, ".op_bus"}, 90'(op), 90'(eop));
   endtask

   initial forever begin
      @(negedge clk);
      if (chk_en) begin
         check_inst("s0", 0, busy0, done0, sig0, cnt0, op0);
         check_inst("s2", 1, busy2, done2, sig2, cnt2, op2);
      end
   end

   // ---------------- dut_y driver ----------------
   bit          y_rand = 1'b0;
   logic [89:0] y_fix  = 90'h0;

   initial forever begin
      @(negedge clk);
      if (y_rand) dut_y = {26'($urandom), $urandom, $urandom};
      else        dut_y = y_fix;
   end

   // ---------------- stimulus ----------------
   task automatic wait_idle(input int lim, input int stall_pct);
      int k = 0;
      while ((m_run[0] || m_run[1] || m_fin[0] || m_fin[1]) && k < lim) begin
         @(negedge clk);
         stall = ($urandom_range(0, 99) < stall_pct);
         k++;
      end
      stall = 1'b0;
      @(negedge clk);
      if (k >= lim) chk("wait_idle_timeout", 90'(k), 90'(0));
   endtask

   task automatic launch(input logic [31:0] s, input logic [15:0] n);
      seed    = s;
      num_vec = n;
      start   = 1'b1;
      @(negedge clk);
      start   = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got running want finished");
      $fatal(1, "timeout");
   end

   logic [31:0] ref_sig;
   int          bc;
   bit          seen;

   initial begin
      rst = 1'b1; start = 1'b0; stall = 1'b0; seed = 32'h0; num_vec = 16'h0;
      dut_y = 90'h0;
      repeat (2) @(negedge clk);
      chk_en = 1'b1;
      chk("rst.busy", 90'(busy0), 90'(0));
      chk("rst.done", 90'(done2), 90'(0));
      chk("rst.sig", 90'(sig0), 90'(0));
      chk("rst.cnt", 90'(cnt2), 90'(0));
      chk("rst.op", 90'(op0), 90'(0));
      rst = 1'b0;
      @(negedge clk);

      // Single vector, zero result.
      y_rand = 1'b0; y_fix = 90'h0;
      launch(32'h1, 16'd1);
      chk("t1.busy", 90'(busy0), 90'(1));
      chk("t1.op", 90'(op0), 90'(60'h0000001_00000001));
      @(negedge clk);
      chk("t1.done", 90'(done0), 90'(1));
      chk("t1.sig", 90'(sig0), 90'(32'hFB3E_E249));
      chk("t1.cnt", 90'(cnt0), 90'(1));
      wait_idle(50, 0);
      chk("t1.sig_s2", 90'(sig2), 90'(32'hFB3E_E249));

      // Empty run.
      launch(32'h1234, 16'd0);
      chk("t2.done0", 90'(done0), 90'(1));
      chk("t2.done2", 90'(done2), 90'(1));
      chk("t2.busy", 90'(busy2), 90'(0));
      chk("t2.sig", 90'(sig2), 90'(32'hFFFF_FFFF));
      chk("t2.cnt", 90'(cnt0), 90'(0));
      wait_idle(10, 0);

      // Stalled vs unstalled run with a fixed result.
      y_fix = 90'h3_1415_9265_3589_7932_3846;
      launch(32'hACE1_0001, 16'd2);
      wait_idle(50, 0);
      ref_sig = m_sig[1];
      launch(32'hACE1_0001, 16'd2);
      bc = 0; seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
         if (done2) begin
            seen = 1'b1;
            chk("t3.sig", 90'(sig2), 90'(ref_sig));
         end
         if (busy2) bc++;
         stall = (bc >= 2 && bc < 5);
         if (!seen) @(negedge clk);
      end
      stall = 1'b0;
      chk("t3.done_seen", 90'(seen), 90'(1));
      chk("t3.busy_cycles", 90'(bc), 90'(9));
      wait_idle(50, 0);

      // Zero seed behaves as seed 1.
      y_rand = 1'b1;
      launch(32'h0, 16'd5);
      chk("t4.op", 90'(op0), 90'(60'h0000001_00000001));
      wait_idle(100, 0);

      // Ignored start mid-run, then reset mid-run with start and stall also high.
      launch($urandom, 16'd50);
      repeat (4) @(negedge clk);
      launch(32'h5555_AAAA, 16'd7);
      repeat (10) @(negedge clk);
      rst = 1'b1; start = 1'b1; stall = 1'b1;
      @(negedge clk);
      rst = 1'b0; start = 1'b0; stall = 1'b0;
      chk("t5.busy0", 90'(busy0), 90'(0));
      chk("t5.busy2", 90'(busy2), 90'(0));
      chk("t5.sig", 90'(sig2), 90'(0));
      chk("t5.cnt", 90'(cnt0), 90'(0));
      chk("t5.op", 90'(op2), 90'(0));
      launch(32'hC0FF_EE11, 16'd3);
      wait_idle(100, 20);

      // Short random runs with random stalls.
      for (int r = 0; r < 6; r++) begin
         launch($urandom, 16'($urandom_range(1, 20)));
         wait_idle(400, 25);
      end

      // Long random run.
      launch($urandom, 16'd1000);
      wait_idle(6000, 10);
      chk("t6.cnt0", 90'(cnt0), 90'(1000));
      chk("t6.cnt2", 90'(cnt2), 90'(1000));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
